// File: rtl/sd_result_checker.sv
// Sudoku result checker: loads an 81-cell puzzle, merges the solver's 15 fill
// values into the empty cells, then checks all 27 groups and reports a verdict.
module sd_result_checker (
  input  logic       clk,
  input  logic       rst,
  input  logic       puz_valid,
  input  logic [3:0] puz,
  input  logic       sol_valid,
  input  logic [3:0] sol,
  output logic       chk_valid,
  output logic [1:0] chk
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_LOAD   = 3'd1;
  localparam logic [2:0] S_WAIT   = 3'd2;
  localparam logic [2:0] S_FILL   = 3'd3;
  localparam logic [2:0] S_CHECK  = 3'd4;
  localparam logic [2:0] S_REPORT = 3'd5;

  logic [2:0] state;
  logic [3:0] grid  [9][9];
  logic [3:0] pos_r [15];
  logic [3:0] pos_c [15];
  logic [3:0] ld_r, ld_c;
  logic [6:0] ecnt, bcnt;
  logic [4:0] grp;
  logic       f_proto, f_fail, f_inv;
  logic [1:0] rpt;
  logic [8:0] grp_or;
  logic [7:0] rc;
  logic       grp_ok;
  logic       fail_beat, bad_beat;

  function automatic logic [8:0] onehot(input logic [3:0] v);
    logic [8:0] oh;
    oh = '0;
    if (v >= 4'd1 && v <= 4'd9) oh[v - 4'd1] = 1'b1;
    return oh;
  endfunction

  // Packed {row, col} of member i of group g (rows, then columns, then boxes).
  function automatic logic [7:0] cell_rc(input logic [4:0] g, input int i);
    int gi, r, c, b;
    gi = int'(g);
    b  = 0;
    if (gi < 9) begin
      r = gi;
      c = i;
    end else if (gi < 18) begin
      r = i;
      c = gi - 9;
    end else begin
      b = gi - 18;
      r = 3 * (b / 3) + i / 3;
      c = 3 * (b % 3) + i % 3;
    end
    return {4'(r), 4'(c)};
  endfunction

  always_comb begin
    grp_or = '0;
    rc     = '0;
    for (int i = 0; i < 9; i++) begin
      rc     = cell_rc(grp, i);
      grp_or = grp_or | onehot(grid[rc[7:4]][rc[3:0]]);
    end
  end

  assign grp_ok    = (grp_or == 9'h1FF);
  assign fail_beat = (bcnt == 7'd0) && (sol == 4'd10);
  assign bad_beat  = (sol == 4'd0) || (sol > 4'd9);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= S_IDLE;
      ld_r    <= '0;
      ld_c    <= '0;
      ecnt    <= '0;
      bcnt    <= '0;
      grp     <= '0;
      f_proto <= 1'b0;
      f_fail  <= 1'b0;
      f_inv   <= 1'b0;
      rpt     <= '0;
      for (int r = 0; r < 9; r++)
        for (int c = 0; c < 9; c++)
          grid[r][c] <= '0;
      for (int k = 0; k < 15; k++) begin
        pos_r[k] <= '0;
        pos_c[k] <= '0;
      end
    end else begin
      case (state)
        S_IDLE, S_LOAD: begin
          if (puz_valid) begin
            state <= S_LOAD;
            if (ld_r < 4'd9) begin
              grid[ld_r][ld_c] <= puz;
              if (puz == 4'd0) begin
                if (ecnt < 7'd15) begin
                  pos_r[ecnt[3:0]] <= ld_r;
                  pos_c[ecnt[3:0]] <= ld_c;
                end
                ecnt <= ecnt + 7'd1;
              end
              if (ld_c == 4'd8) begin
                ld_c <= '0;
                ld_r <= ld_r + 4'd1;
              end else begin
                ld_c <= ld_c + 4'd1;
              end
            end else begin
              f_proto <= 1'b1;
            end
          end else if (state == S_LOAD) begin
            state <= S_WAIT;
            if (ecnt != 7'd15 || ld_r != 4'd9) f_proto <= 1'b1;
          end
        end
        S_WAIT, S_FILL: begin
          if (sol_valid) begin
            state <= S_FILL;
            if (fail_beat) begin
              f_fail <= 1'b1;
            end else begin
              if (bad_beat) f_inv <= 1'b1;
              if (bcnt < 7'd15)
                grid[pos_r[bcnt[3:0]]][pos_c[bcnt[3:0]]] <= sol;
            end
            if (bcnt >= 7'd15) f_proto <= 1'b1;
            if (bcnt != 7'h7F) bcnt <= bcnt + 7'd1;
          end else if (state == S_FILL) begin
            if (f_fail && bcnt == 7'd1) begin
              rpt   <= 2'd1;
              state <= S_REPORT;
            end else if (f_proto || bcnt != 7'd15) begin
              rpt   <= 2'd3;
              state <= S_REPORT;
            end else begin
              // Group 0 is checked in this same cycle so the sweep ends on time.
              if (!grp_ok) f_inv <= 1'b1;
              grp   <= 5'd1;
              state <= S_CHECK;
            end
          end
        end
        S_CHECK: begin
          if (!grp_ok) f_inv <= 1'b1;
          if (grp == 5'd26) state <= S_REPORT;
          else              grp   <= grp + 5'd1;
        end
        S_REPORT: begin
          state   <= S_IDLE;
          ld_r    <= '0;
          ld_c    <= '0;
          ecnt    <= '0;
          bcnt    <= '0;
          grp     <= '0;
          f_proto <= 1'b0;
          f_fail  <= 1'b0;
          f_inv   <= 1'b0;
          rpt     <= '0;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign chk_valid = (state == S_REPORT);
  assign chk       = (state != S_REPORT) ? 2'd0 :
                     (rpt != 2'd0)       ? rpt  :
                     (f_inv ? 2'd2 : 2'd0);

endmodule

// File: tb/tb_sd_result_checker.sv
// Scoreboard bench for sd_result_checker: directed puzzles and solver streams,
// verdict code and arrival cycle checked by an independent monitor.
module tb_sd_result_checker;

  logic       clk = 1'b0;
  logic       rst;
  logic       puz_valid;
  logic [3:0] puz;
  logic       sol_valid;
  logic [3:0] sol;
  logic       chk_valid;
  logic [1:0] chk;

  int n_assert = 0;
  int n_fail   = 0;
  int cyc      = 0;

  logic [1:0] exp_code [$];
  int         exp_cyc  [$];
  logic [3:0] bt [20];

  sd_result_checker dut (
    .clk       (clk),
    .rst       (rst),
    .puz_valid (puz_valid),
    .puz       (puz),
    .sol_valid (sol_valid),
    .sol       (sol),
    .chk_valid (chk_valid),
    .chk       (chk)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Known-valid solved grid.
  function automatic logic [3:0] sv(input int idx);
    int r, c;
    r = idx / 9;
    c = idx % 9;
    return 4'(((r * 3 + r / 3 + c) % 9) + 1);
  endfunction

  // Empty cells are indices 2, 7, 12, ... 72 (first nzero of them).
  function automatic bit is_empty(input int idx, input int nzero);
    return (idx % 5 == 2) && (idx / 5 < nzero);
  endfunction

  task automatic set_good_beats();
    for (int k = 0; k < 20; k++) bt[k] = (k < 15) ? sv(k * 5 + 2) : 4'd1;
  endtask

  task automatic load_puzzle(input int nzero, input bit sol_on_exit);
    for (int i = 0; i < 81; i++) begin
      puz_valid = 1'b1;
      puz       = is_empty(i, nzero) ? 4'd0 : sv(i);
      @(posedge clk); #1;
    end
    puz_valid = 1'b0;
    puz       = 4'd0;
    if (sol_on_exit) begin
      sol_valid = 1'b1;
      sol       = 4'd5;
    end
    @(posedge clk); #1;
    sol_valid = 1'b0;
    sol       = 4'd0;
    @(posedge clk); #1;
  endtask

  task automatic send_beats(input int n);
    for (int k = 0; k < n; k++) begin
      sol_valid = 1'b1;
      sol       = bt[k];
      @(posedge clk); #1;
    end
    sol_valid = 1'b0;
    sol       = 4'd0;
  endtask

  task automatic expect_verdict(input logic [1:0] code);
    exp_code.push_back(code);
    exp_cyc.push_back(cyc + ((code == 2'd1 || code == 2'd3) ? 1 : 27));
  endtask

  task automatic wait_verdict(input string name);
    bit seen;
    seen = 1'b0;
    for (int t = 0; t < 60 && !seen; t++) begin
      @(posedge clk); #1;
      if (chk_valid) seen = 1'b1;
    end
    if (!seen) begin
      n_assert++;
      n_fail++;
      $display("FAIL %s: timeout, chk_valid=0 after 60 cycles, required a pulse", name);
    end
  endtask

  task automatic run(input string name, input int nzero, input int nbeats,
                     input logic [1:0] code);
    load_puzzle(nzero, 1'b0);
    send_beats(nbeats);
    expect_verdict(code);
    wait_verdict(name);
    @(posedge clk); #1;
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (chk_valid) begin
        if (exp_code.size() == 0) begin
          n_assert++;
          n_fail++;
          $display("FAIL unexpected_verdict: chk_valid=1 chk=%0d at cycle %0d, required no pulse",
                   chk, cyc);
        end else begin
          logic [1:0] ec;
          int         et;
          ec = exp_code.pop_front();
          et = exp_cyc.pop_front();
          n_assert++;
          if (chk !== ec) begin
            n_fail++;
            $display("FAIL verdict_code: chk=%0d, required %0d", chk, ec);
          end
          n_assert++;
          if (cyc != et) begin
            n_fail++;
            $display("FAIL verdict_latency: pulse at cycle %0d, required cycle %0d", cyc, et);
          end
        end
      end else begin
        n_assert++;
        if (chk !== 2'd0) begin
          n_fail++;
          $display("FAIL chk_idle: chk=%0d while chk_valid=0, required 0", chk);
        end
      end
    end
  end

  initial begin
    rst = 1'b1; puz_valid = 1'b0; puz = 4'd0; sol_valid = 1'b0; sol = 4'd0;
    #1;
    n_assert++;
    if (chk_valid !== 1'b0 || chk !== 2'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: chk_valid=%0b chk=%0d, required 0/0", chk_valid, chk);
    end
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk); #1;

    // Valid run; a stray sol beat on the LOAD exit cycle must be ignored.
    set_good_beats();
    load_puzzle(15, 1'b1);
    send_beats(15);
    expect_verdict(2'd0);
    wait_verdict("valid");
    @(posedge clk); #1;

    set_good_beats(); bt[0] = 4'd10;
    run("solver_fail", 15, 1, 2'd1);

    // Swap two fills from rows 0 and 1: row 0 repeats a digit.
    set_good_beats(); bt[1] = sv(12); bt[2] = sv(7);
    run("row_repeat", 15, 15, 2'd2);

    set_good_beats();
    run("fourteen_zeros", 14, 15, 2'd3);

    set_good_beats();
    run("sixteen_beats", 15, 16, 2'd3);

    set_good_beats(); bt[5] = 4'd11;
    run("bad_value", 15, 15, 2'd2);

    // Beat-0 "no solution" followed by more beats: cell stays empty.
    set_good_beats(); bt[0] = 4'd10;
    run("late_nosol", 15, 15, 2'd2);

    // Reset at check group 10 aborts silently.
    set_good_beats();
    load_puzzle(15, 1'b0);
    send_beats(15);
    repeat (10) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    n_assert++;
    if (chk_valid !== 1'b0 || chk !== 2'd0) begin
      n_fail++;
      $display("FAIL midcheck_reset: chk_valid=%0b chk=%0d, required 0/0", chk_valid, chk);
    end
    @(posedge clk); #1 rst = 1'b0;
    repeat (40) @(posedge clk);
    #1;
    set_good_beats();
    run("after_reset", 15, 15, 2'd0);

    // Back-to-back: second puzzle starts the cycle after REPORT.
    set_good_beats();
    load_puzzle(15, 1'b0);
    send_beats(15);
    expect_verdict(2'd0);
    wait_verdict("b2b_first");
    @(posedge clk); #1;
    set_good_beats(); bt[1] = sv(12); bt[2] = sv(7);
    run("b2b_second", 15, 15, 2'd2);

    repeat (5) @(posedge clk);
    #1;
    n_assert++;
    if (exp_code.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: %0d verdicts outstanding, required 0", exp_code.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
